// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with fixed or round-robin priority.
// The winner is held behind a valid/ready handshake until the consumer accepts it.
module priority_encoder_rr #(
    parameter int N    = 8,
    parameter int MODE = 0,
    parameter int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    localparam logic [0:0]   IDLE    = 1'b0;
    localparam logic [0:0]   HOLD    = 1'b1;
    localparam logic [W-1:0] PTR_TOP = W'(N - 1);

    logic [0:0]   state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] oh_q, oh_d;

    logic         accept;
    logic         capture;
    logic [W-1:0] start;
    logic [W-1:0] win;
    logic         found;
    logic [N-1:0] oh_win;

    always_comb begin
        accept  = (state_q == HOLD) && out_ready;
        capture = (state_q == IDLE) || out_ready;
    end

    // The accepted index becomes lowest priority; a same-edge capture sees it.
    always_comb begin
        ptr_d = ptr_q;
        if (MODE == 1 && accept) begin
            ptr_d = (idx_q == '0) ? PTR_TOP : idx_q - W'(1);
        end
        start = (MODE == 1) ? ptr_d : PTR_TOP;
    end

    always_comb begin
        int           j;
        logic [W-1:0] jj;
        win   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) - k;
            if (j < 0) begin
                j = j + N;
            end
            jj = W'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                win   = jj;
            end
        end
        oh_win = {{(N-1){1'b0}}, 1'b1} << win;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        if (capture) begin
            if (found) begin
                state_d = HOLD;
                idx_d   = win;
                oh_d    = oh_win;
            end else begin
                state_d = IDLE;
                oh_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= PTR_TOP;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            oh_q    <= oh_d;
        end
    end

    always_comb begin
        out_valid  = (state_q == HOLD);
        out_idx    = idx_q;
        out_onehot = oh_q;
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three configurations driven in lockstep,
// scoreboard queues filled by a reference model and drained by a monitor.
module tb_priority_encoder_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] req_a [3];
    logic       rdy_a [3];

    logic       v0, v1, v2;
    logic [2:0] i0, i1, i2;
    logic [7:0] o0, o1;
    logic [4:0] o2;

    logic       v_a  [3];
    logic [2:0] idx_a[3];
    logic [7:0] oh_a [3];

    assign v_a[0]   = v0;
    assign v_a[1]   = v1;
    assign v_a[2]   = v2;
    assign idx_a[0] = i0;
    assign idx_a[1] = i1;
    assign idx_a[2] = i2;
    assign oh_a[0]  = o0;
    assign oh_a[1]  = o1;
    assign oh_a[2]  = {3'b000, o2};

    priority_encoder_rr #(.N(8), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req_a[0]),
        .out_valid(v0), .out_ready(rdy_a[0]),
        .out_idx(i0), .out_onehot(o0)
    );

    priority_encoder_rr #(.N(8), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req_a[1]),
        .out_valid(v1), .out_ready(rdy_a[1]),
        .out_idx(i1), .out_onehot(o1)
    );

    priority_encoder_rr #(.N(5), .MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req_a[2][4:0]),
        .out_valid(v2), .out_ready(rdy_a[2]),
        .out_idx(i2), .out_onehot(o2)
    );

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    bit mvalid[3];
    int mptr  [3];
    int mg    [3];
    int q0[$];
    int q1[$];
    int q2[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int nof(int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int modeof(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // Scan downward from s with wrap; first requesting input wins.
    function automatic int search(int i, logic [7:0] r, int s);
        int n;
        int j;
        n = nof(i);
        for (int k = 0; k < n; k++) begin
            j = (s - k + n) % n;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic push(int i, int g);
        case (i)
            0: q0.push_back(g);
            1: q1.push_back(g);
            default: q2.push_back(g);
        endcase
    endtask

    task automatic pop(int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    function automatic int qsize(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int front(int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mvalid[i] = 1'b0;
            mptr[i]   = nof(i) - 1;
            mg[i]     = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic model_edge(int i);
        int  n;
        int  g;
        bit  acc;
        bit  cap;
        n   = nof(i);
        acc = mvalid[i] && rdy_a[i];
        cap = !mvalid[i] || rdy_a[i];
        if (modeof(i) == 1 && acc) begin
            mptr[i] = (mg[i] == 0) ? n - 1 : mg[i] - 1;
        end
        if (cap) begin
            if (req_a[i] != 8'h00) begin
                g = search(i, req_a[i], (modeof(i) == 1) ? mptr[i] : n - 1);
                mg[i]     = g;
                mvalid[i] = 1'b1;
                push(i, g);
            end else begin
                mvalid[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle(logic [7:0] r, logic [2:0] rm);
        for (int i = 0; i < 3; i++) begin
            req_a[i] = (i == 2) ? (r & 8'h1F) : r;
            rdy_a[i] = rm[i];
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && run) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("valid[%0d]", i), int'(v_a[i]), int'(mvalid[i]));
                if (v_a[i]) begin
                    chk($sformatf("sb_depth[%0d]", i), qsize(i), 1);
                    if (qsize(i) > 0) begin
                        chk($sformatf("idx[%0d]", i), int'(idx_a[i]), front(i));
                        chk($sformatf("onehot[%0d]", i), int'(oh_a[i]),
                            1 << front(i));
                        if (rdy_a[i]) pop(i);
                    end
                end else begin
                    chk($sformatf("onehot_idle[%0d]", i), int'(oh_a[i]), 0);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic [2:0] rm;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_a[i] = 8'h00;
            rdy_a[i] = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid[%0d]", i), int'(v_a[i]), 0);
            chk($sformatf("rst_idx[%0d]", i), int'(idx_a[i]), 0);
            chk($sformatf("rst_onehot[%0d]", i), int'(oh_a[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        cycle(8'hA0, 3'b111);
        cycle(8'h00, 3'b111);
        cycle(8'h00, 3'b111);

        cycle(8'h24, 3'b111);
        repeat (5) cycle(8'h01, 3'b000);
        cycle(8'h01, 3'b111);
        cycle(8'h00, 3'b111);

        repeat (10) cycle(8'hFF, 3'b111);
        cycle(8'h00, 3'b111);
        repeat (5) cycle(8'h81, 3'b111);
        cycle(8'h00, 3'b111);
        repeat (8) cycle(8'h16, 3'b111);
        cycle(8'h00, 3'b111);

        repeat (400) begin
            case ($urandom_range(0, 3))
                0: r = 8'h00;
                1: r = 8'($urandom);
                2: r = 8'($urandom & $urandom);
                default: r = 8'h01 << $urandom_range(0, 7);
            endcase
            for (int b = 0; b < 3; b++) rm[b] = ($urandom_range(0, 3) != 0);
            cycle(r, rm);
        end

        // Leave the round-robin pointer at 0 before an abrupt reset.
        cycle(8'h00, 3'b111);
        cycle(8'h00, 3'b111);
        cycle(8'h02, 3'b111);
        cycle(8'h40, 3'b111);
        for (int i = 0; i < 3; i++) rdy_a[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pre_rst_valid[%0d]", i), int'(v_a[i]), 1);
            chk($sformatf("pre_rst_idx[%0d]", i), int'(idx_a[i]), 6);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_valid[%0d]", i), int'(v_a[i]), 0);
            chk($sformatf("async_idx[%0d]", i), int'(idx_a[i]), 0);
            chk($sformatf("async_onehot[%0d]", i), int'(oh_a[i]), 0);
        end
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        cycle(8'h03, 3'b111);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post_rst_idx[%0d]", i), int'(idx_a[i]), 1);
        end
        repeat (4) cycle(8'h81, 3'b111);
        repeat (3) cycle(8'h00, 3'b111);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_drain[%0d]", i), qsize(i), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_encoder_rr.md
Name: priority_encoder_rr

Overview:
Parametrised, registered successor to the team's 8:3 combinational priority encoder. It takes an N-bit request vector and selects one winner, using either fixed priority (highest index wins) or round-robin rotating priority. The winner is presented as a binary index plus a one-hot vector behind a valid/ready output handshake. It sits between request sources (interrupt lines, channel requests) and a single downstream consumer that may apply backpressure.

Parameters:
- N, default 8: number of request inputs; legal range 2..256.
- MODE, default 0: 0 = fixed priority (bit N-1 highest, bit 0 lowest); 1 = round-robin.
- W, default $clog2(N): index width; must equal $clog2(N) (3 for N=8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; sampled only on a capture edge.
- out_valid  output  1  a registered winner is present.
- out_ready  input  1  consumer accepts the winner when out_valid and out_ready are both 1.
- out_idx  output  W  binary index of the winner.
- out_onehot  output  N  one-hot winner; equals 1<<out_idx while out_valid=1, else 0.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n=0):
  - out_valid=0, out_idx=0, out_onehot=0.
  - Round-robin pointer ptr=N-1; state=IDLE.
  - A pending, unaccepted grant is discarded.
- States: IDLE (out_valid=0) and HOLD (out_valid=1).
- Capture edge: any edge where the state is IDLE, or the state is HOLD and out_ready=1.
  - If req!=0: register the winner, out_valid=1, go to (or stay in) HOLD.
  - If req==0: out_valid=0, out_onehot=0, out_idx keeps its last value, state=IDLE.
- Latency: the winner appears 1 cycle after req is sampled. There is no combinational path from req or out_ready to any output.
- Throughput: one grant per cycle while out_ready=1 and req!=0 (back-to-back captures, no bubble).
- HOLD with out_ready=0: out_idx, out_onehot and out_valid stay stable; req changes are ignored. A grant is held even if its request drops.
- Winner search:
  - Search runs in descending index order, starting at index s and wrapping N-1 -> 0.
  - The first set bit of req wins.
  - MODE=0: s=N-1 always.
  - MODE=1: s=ptr.
- Pointer update (MODE=1 only): on every accept (out_valid && out_ready) of winner g, ptr <= (g==0) ? N-1 : g-1. The granted index becomes lowest priority.
  - When a capture coincides with an accept, the search uses the updated pointer, i.e. s derived from the accepted g.
  - ptr does not change without an accept. In MODE=0, ptr is held at N-1.
- Arithmetic: pointer decrement wraps modulo N. This holds for non-power-of-two N, where indices >= N never win.
- Invariant: out_onehot has at most one bit set; it is all-zero if and only if out_valid=0.

Test Plan:
1. MODE=0, N=8, out_ready=1, req=8'hA0 for one cycle -> next cycle out_valid=1, out_idx=7, out_onehot=8'h80; the cycle after that, with req=0, out_valid=0.
2. Backpressure, MODE=0: req=8'h24 captured, out_ready=0 for 5 cycles while req changes to 8'h01 -> out_idx=5 and out_onehot=8'h20 stay stable. Raise out_ready -> next grant is idx 0.
3. MODE=1, req=8'hFF held, out_ready=1 -> grant sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles with no gaps.
4. MODE=1, req=8'h81 held, out_ready=1 -> 7,0,7,0. Same stimulus with MODE=0 -> 7,7,7,7.
5. MODE=1, N=5, req=5'b10110 held -> 4,2,1,4,2 (wrap across non-power-of-two N). Check out_idx never exceeds 4.
6. Reset mid-HOLD: out_valid=1, idx=6; drop rst_n asynchronously mid-cycle -> all outputs 0 immediately, ptr=N-1. After release, req=8'h03 -> out_idx=1.
